// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and the hex-to-segment decode for the
//               eight-digit common-anode seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [7:0] an_t;

    // gfedcba, active-low: a 0 bit lights the segment
    localparam seg_t SEG_LUT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    localparam seg_t SEG_OFF = 7'h7F;
    localparam an_t  AN_OFF  = 8'hFF;

    // Active-low one-hot anode select for a digit index
    function automatic an_t an_select(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_if
// Description : Display-word and pin bundle between the board wrapper
//               (master) and the seven-segment scan driver (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if;

    logic [31:0] data;
    logic        load;
    logic        freeze;
    logic        lzs_en;
    logic [7:0]  dp;
    logic [7:0]  blank_mask;
    logic [6:0]  seg;
    logic        dp_n;
    logic [7:0]  an;
    logic        frame_done;

    modport master (
        output data, load, freeze, lzs_en, dp, blank_mask,
        input  seg, dp_n, an, frame_done
    );

    modport slave (
        input  data, load, freeze, lzs_en, dp, blank_mask,
        output seg, dp_n, an, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/seg7_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : seg7_tick_gen
// Description : Free-running prescaler counting 0..DIV-1; o_tick is high for
//               the single cycle the count sits at DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    output logic      o_tick
);

    localparam int unsigned         CW     = $clog2(DIV);
    localparam logic [CW-1:0]       C_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Prescaler: wrap to zero after the last count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Eight-digit multiplexed seven-segment driver with frame
//               snapshotting, freeze, per-digit blanking, leading-zero
//               suppression, decimal points and an anti-ghosting dead time.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned SCAN_HZ   = 3040,
    // Dead cycles after each digit change; must stay below DIV
    parameter int unsigned BLANK_CYC = 64
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seg7_scan_driver_if.slave  bus
);

    localparam int unsigned   DIV     = CLK_HZ / SCAN_HZ;
    localparam int unsigned   BW      = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [BW-1:0] C_BLANK = BW'(BLANK_CYC);

    logic          w_tick;
    logic          w_boundary;
    logic [2:0]    r_idx;
    logic [31:0]   r_shadow;
    logic [31:0]   r_disp;
    logic [BW-1:0] r_blank;
    logic [7:0]    w_lz_above;
    logic [3:0]    w_nib;
    logic          w_dark;
    an_t           w_an_nxt;
    seg_t          w_seg_nxt;
    logic          w_dpn_nxt;
    an_t           r_an;
    seg_t          r_seg;
    logic          r_dp_n;
    logic          r_frame_done;

    seg7_tick_gen #(
        .DIV    (DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // The tick leaving digit 7 closes the frame
    assign w_boundary = w_tick && (r_idx == 3'd7);

    // Digit index advances once per prescaler period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 3'd0;
        end else if (w_tick) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // Shadow register follows every load strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (bus.load) begin
            r_shadow <= bus.data;
        end
    end

    // Frame snapshot only at the boundary so a frame never mixes two words;
    // a load on the boundary cycle itself bypasses the shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp <= '0;
        end else if (w_boundary && !bus.freeze) begin
            r_disp <= bus.load ? bus.data : r_shadow;
        end
    end

    // Dead-time counter: reloaded at every digit change, then runs to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank <= C_BLANK;
        end else if (w_tick) begin
            r_blank <= C_BLANK;
        end else if (r_blank != '0) begin
            r_blank <= r_blank - BW'(1);
        end
    end

    // w_lz_above[i]: nibbles 7..i of the frame are all zero
    for (genvar i = 0; i < 8; i++) begin : g_lz
        assign w_lz_above[i] = (r_disp[31:4*i] == '0);
    end

    assign w_nib  = r_disp[{r_idx, 2'b00} +: 4];
    assign w_dark = bus.blank_mask[r_idx]
                  | (bus.lzs_en & (r_idx != 3'd0) & w_lz_above[r_idx]);

    // Next pin values: all anodes off during dead time, else scan the digit
    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_OFF;
        w_dpn_nxt = 1'b1;
        if (r_blank == '0) begin
            w_an_nxt = an_select(r_idx);
            if (!w_dark) begin
                w_seg_nxt = SEG_LUT[w_nib];
                w_dpn_nxt = ~bus.dp[r_idx];
            end
        end
    end

    // Registered pins and frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dp_n       <= w_dpn_nxt;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp_n       = r_dp_n;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
